// File: rtl/seven_segment_scan_decoder_cgrundey_pkg.sv
// Shared definitions for the seven-segment scan decoder: the active-low
// segment patterns (bit0 = a ... bit6 = g) and the scan FSM encodings.
package seven_segment_scan_decoder_cgrundey_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_e;

    // Hex digit to its active-low segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_segment_scan_decoder_cgrundey_if.sv
// Multiplexed display bus being snooped, plus the reconstructed digit view.
interface seven_segment_scan_decoder_cgrundey_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_done;
    logic                    err_pulse;
    logic [2:0]              err_digit;

    // Side that drives the display bus and consumes the decoded view.
    modport master (
        output seg_in, an_in,
        input  digits_out, digit_valid, frame_done, err_pulse, err_digit
    );

    // The scan decoder itself.
    modport slave (
        input  seg_in, an_in,
        output digits_out, digit_valid, frame_done, err_pulse, err_digit
    );
endinterface

// File: rtl/seven_segment_pattern_decoder_cgrundey.sv
// Combinational map from an active-low segment pattern to a hex value.
module seven_segment_pattern_decoder_cgrundey
    import seven_segment_scan_decoder_cgrundey_pkg::*;
(
    input  logic [6:0] seg,
    output logic       is_valid,
    output logic       is_blank,
    output logic [3:0] hex
);

    // Search the shared pattern table so the decoder never drifts from the driver.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        is_valid = 1'b0;
        hex      = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == hex_to_seg(4'(i))) begin
                is_valid = 1'b1;
                hex      = 4'(i);
            end
        end
        is_blank = (seg == SEG_BLANK);
    end

endmodule

// File: rtl/seven_segment_scan_decoder_cgrundey.sv
// Snoops a time-multiplexed active-low seven-segment bus and rebuilds the
// hex value on each digit once the bus has been steady long enough.
module seven_segment_scan_decoder_cgrundey
    import seven_segment_scan_decoder_cgrundey_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    seven_segment_scan_decoder_cgrundey_if.slave bus
);

    localparam int         SW       = NUM_DIGITS + 7;
    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    logic [SW-1:0]           s_d, s_q;
    logic                    s_changed;
    logic [7:0]              run_cnt;
    scan_state_e             state_q, state_d;
    logic                    capture;
    logic                    next_one_low;
    logic [NUM_DIGITS-1:0]   cap_sel;
    logic [2:0]              cap_idx;
    logic                    dec_valid, dec_blank;
    logic [3:0]              dec_hex;
    logic [NUM_DIGITS-1:0]   captured_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    frame_q, err_q;
    logic [2:0]              err_digit_q;

    // True when exactly one active-low enable is asserted.
    function automatic logic exactly_one_low(input logic [NUM_DIGITS-1:0] an);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) n++;
        end
        return (n == 1);
    endfunction

    assign s_d          = {bus.an_in, bus.seg_in};
    assign s_changed    = (s_d != s_q);
    assign next_one_low = exactly_one_low(s_d[SW-1:7]);
    assign cap_sel      = ~s_q[SW-1:7];

    // Index of the single enabled digit held in the input register.
    always_comb begin
        cap_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) cap_idx = 3'(i);
        end
    end

    seven_segment_pattern_decoder_cgrundey u_decoder (
        .seg      (s_q[6:0]),
        .is_valid (dec_valid),
        .is_blank (dec_blank),
        .hex      (dec_hex)
    );

    // Input register and run-length counter (saturating, restarts at 1 on change).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            s_q     <= '1;
            run_cnt <= 8'd0;
        end else begin
            s_q <= s_d;
            if (s_changed) begin
                run_cnt <= 8'd1;
            end else if (state_q == ST_SETTLE && run_cnt < STABLE_N) begin
                run_cnt <= run_cnt + 8'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and capture strobe.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (state_q == ST_SETTLE && run_cnt == STABLE_N) begin
            capture = 1'b1;
            state_d = ST_HELD;
        end
        if (s_changed) begin
            state_d = next_one_low ? ST_SETTLE : ST_IDLE;
        end
    end

    // Capture registers, error reporting and frame-completion mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q    <= '0;
            valid_q     <= '0;
            captured_q  <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= 3'd0;
        end else begin
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            if (capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cap_sel[i]) begin
                        if (dec_valid) digits_q[4*i +: 4] <= dec_hex;
                        valid_q[i] <= dec_valid;
                    end
                end
                if (!dec_valid && !dec_blank) begin
                    err_q       <= 1'b1;
                    err_digit_q <= cap_idx;
                end
                if ((captured_q | cap_sel) == '1) begin
                    frame_q    <= 1'b1;
                    captured_q <= '0;
                end else begin
                    captured_q <= captured_q | cap_sel;
                end
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.err_pulse   = err_q;
    assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder_cgrundey.sv
// Directed bench for the seven-segment scan decoder (4 digits, 8-cycle settle).
module tb_seven_segment_scan_decoder_cgrundey;
    import seven_segment_scan_decoder_cgrundey_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_cnt  = 0;
    int   frame_cnt = 0;
    int   err_base, frame_base;

    seven_segment_scan_decoder_cgrundey_if #(.NUM_DIGITS(4)) bus ();

    seven_segment_scan_decoder_cgrundey #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.err_pulse)  err_cnt++;
        if (bus.frame_done) frame_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Drive the bus at a falling edge and hold it for n clock cycles.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        bus.an_in  = 4'hF;
        bus.seg_in = SEG_BLANK;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_digits", bus.digits_out, 0);
        check("rst_valid", bus.digit_valid, 0);
        check("rst_frame", bus.frame_done, 0);
        check("rst_err", bus.err_pulse, 0);
        check("rst_err_digit", bus.err_digit, 0);

        // Clean capture: nothing after 8 cycles, digit 0 = 3 from cycle 9.
        err_base = err_cnt;
        hold(4'b1110, SEG_3, 8);
        check("clean_not_early", bus.digit_valid, 4'b0000);
        hold(4'b1110, SEG_3, 1);
        check("clean_digit", bus.digits_out[3:0], 4'h3);
        check("clean_valid", bus.digit_valid, 4'b0001);
        hold(4'b1110, SEG_3, 11);
        check("clean_no_err", err_cnt - err_base, 0);

        // Full frame 1, A, F, 0.
        frame_base = frame_cnt;
        err_base   = err_cnt;
        hold(4'b1110, SEG_1, 10);
        hold(4'b1101, SEG_A, 10);
        hold(4'b1011, SEG_F, 10);
        check("frame_not_yet", frame_cnt - frame_base, 0);
        hold(4'b0111, SEG_0, 10);
        check("frame_digits", bus.digits_out, 16'h0FA1);
        check("frame_valid", bus.digit_valid, 4'b1111);
        check("frame_pulses", frame_cnt - frame_base, 1);
        check("frame_no_err", err_cnt - err_base, 0);

        // Glitch rejection on digit 0 holding 5.
        hold(4'b1110, SEG_5, 10);
        check("glitch_pre", bus.digits_out[3:0], 4'h5);
        err_base = err_cnt;
        for (int i = 0; i < 7; i++) begin
            hold(4'b1110, SEG_8, 1);
            check("glitch_hold", bus.digits_out[3:0], 4'h5);
        end
        hold(4'b1110, SEG_5, 10);
        check("glitch_post", bus.digits_out[3:0], 4'h5);
        check("glitch_no_err", err_cnt - err_base, 0);

        // Invalid pattern on digit 2.
        err_base = err_cnt;
        hold(4'b1011, 7'b1010101, 10);
        check("inv_pulses", err_cnt - err_base, 1);
        check("inv_err_digit", bus.err_digit, 2);
        check("inv_valid", bus.digit_valid, 4'b1011);
        check("inv_nibble", bus.digits_out[11:8], 4'hF);

        // Blank on digit 1.
        err_base = err_cnt;
        hold(4'b1101, SEG_BLANK, 10);
        check("blank_valid", bus.digit_valid, 4'b1001);
        check("blank_nibble", bus.digits_out[7:4], 4'hA);
        check("blank_no_err", err_cnt - err_base, 0);

        // Bad enables: none, then two at once.
        err_base   = err_cnt;
        frame_base = frame_cnt;
        hold(4'b1111, SEG_8, 20);
        hold(4'b1100, SEG_8, 20);
        check("bad_en_digits", bus.digits_out, 16'h0FA5);
        check("bad_en_valid", bus.digit_valid, 4'b1001);
        check("bad_en_err", err_cnt - err_base, 0);
        check("bad_en_frame", frame_cnt - frame_base, 0);
        check("bad_en_err_digit", bus.err_digit, 2);

        // Reset mid-frame discards the partial frame.
        hold(4'b1110, SEG_2, 10);
        hold(4'b1101, SEG_7, 10);
        check("pre_rst_digits", bus.digits_out[7:0], 8'h72);
        bus.an_in  = 4'hF;
        bus.seg_in = SEG_BLANK;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_digits", bus.digits_out, 0);
        check("mid_rst_valid", bus.digit_valid, 0);
        check("mid_rst_err_digit", bus.err_digit, 0);
        check("mid_rst_pulses", {30'd0, bus.frame_done, bus.err_pulse}, 0);
        frame_base = frame_cnt;
        hold(4'b1011, SEG_4, 10);
        hold(4'b0111, SEG_9, 10);
        check("post_rst_no_frame", frame_cnt - frame_base, 0);
        check("post_rst_digits", bus.digits_out, 16'h9400);
        check("post_rst_valid", bus.digit_valid, 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_decoder_cgrundey.md
# seven_segment_scan_decoder_cgrundey

Receive-side counterpart of the seven-segment display driver: watches a time-multiplexed, active-low seven-segment bus (shared segment lines plus one active-low enable per digit) and reconstructs the hex value shown on each digit position. Each digit is captured only after the bus has held steady for a programmable number of cycles. The block flags undecodable patterns and pulses once per completed scan frame. It sits in the verification/self-check path beside the display drivers, or on any board input that snoops an external display.

## Interface
- NUM_DIGITS, 4: number of multiplexed digit positions, 1..8.
- STABLE_CYCLES, 8: consecutive identical samples needed before a capture, 2..255.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines, active-low: bit0=a … bit6=g (0 lights a segment).
- an_in  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
- digits_out  output  4*NUM_DIGITS  captured hex values; digit i in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  1 = digit i currently holds a decoded hex value.
- frame_done  output  1  one-cycle pulse when every position has been captured since the last pulse.
- err_pulse  output  1  one-cycle pulse on capture of an undecodable pattern.
- err_digit  output  3  index of the digit that caused the last err_pulse; held between errors.

## Operation
- Decoding uses the team's standard active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank = 1111111.
- Input register: s_q <= {an_in, seg_in} every cycle. The run length counts consecutive cycles with s_q unchanged, and saturates at STABLE_CYCLES.
- State machine:
  - IDLE: s_q has zero enables low, or more than one. No counting and no capture.
  - SETTLE: exactly one enable is low. The counter runs until the run length reaches STABLE_CYCLES, then the block performs a capture and moves to HELD.
  - HELD: no further captures until s_q changes.
  - Any change of s_q goes to SETTLE (single enable) or IDLE (otherwise), and the counter restarts at 1.
- Capture for digit i:
  - Valid pattern: write the hex value to the digit i nibble and set digit_valid[i].
  - Blank: clear digit_valid[i], hold the nibble, no error.
  - Any other pattern: clear digit_valid[i], hold the nibble, assert err_pulse, set err_digit=i.
  - In every case, set captured[i].
- frame_done: asserted on the cycle after the capture that makes the captured mask all-ones. The mask clears in the same cycle.
  - A repeated capture of the same digit before the frame completes only refreshes that digit.
- Simultaneous events: an error capture that also completes the frame pulses err_pulse and frame_done in the same cycle.

## Timing
- Reset values: digits_out=0, digit_valid=0, frame_done=0, err_pulse=0, err_digit=0. Internally: captured=0, counter=0, state=IDLE, s_q=all-ones.
- Capture latency: inputs held constant from cycle 0 give updated outputs from cycle STABLE_CYCLES+1, never earlier.
- A glitch shorter than STABLE_CYCLES never changes any output.
- err_pulse and frame_done are exactly one cycle wide. Each fires at most once per stable interval.
- Reset asserted mid-settle or mid-frame: outputs return to reset values on the next edge, and the partial frame is discarded.

## Structure
- Shared include/package holds:
  - the 16 segment-pattern constants and the blank constant (one source of truth with the display driver);
  - the state encodings IDLE/SETTLE/HELD.
- One sub-module: seven_segment_pattern_decoder_cgrundey. It is combinational and maps 7 bits to {is_valid, is_blank, hex[3:0]}.
- Top level holds the input register, run counter, one-hot-enable check, FSM, capture registers and frame mask. Expected size is 150–250 lines of RTL.

## Test plan
- **Clean capture:** NUM_DIGITS=4, STABLE_CYCLES=8. Drive an_in=1110, seg_in=0110000 for 20 cycles.
  - Required: digits_out[3:0]=3 and digit_valid=0001 from cycle 9, no err_pulse.
- **Full frame:** scan digits 0..3 showing 1,A,F,0, 10 cycles each.
  - Required: digits_out=16'h0FA1, digit_valid=1111, one frame_done pulse after the digit-3 capture.
- **Glitch rejection:** with digit 0 holding 5, show 0000000 for 7 cycles, then return to 0010010.
  - Required: digits_out[3:0] stays 5 throughout, no err_pulse.
- **Invalid and blank:**
  - Digit 2 showing 1010101 for 10 cycles: one err_pulse, err_digit=2, digit_valid[2]=0, nibble held.
  - Digit 1 showing 1111111: digit_valid[1]=0, no err_pulse.
- **Bad enables:** an_in=1111, then an_in=1100, each for 20 cycles.
  - Required: no capture, no pulses, outputs unchanged.
- **Reset mid-frame:** after capturing digits 0–1, assert reset for 1 cycle, then capture digits 2–3 only.
  - Required: all outputs 0 after reset, and no frame_done.
